// File: rtl/mcp_frame_decoder.sv
// mcp_frame_decoder: byte-serial receiver for memory-controller response frames.
// Frame: START | HDR_HI | HDR_LO | payload | CHK | END, where CHK is the XOR of header and payload.
// Good frames update the held data/header/flags. Bad or timed-out frames pulse an error.
module mcp_frame_decoder #(
    parameter logic [7:0]  START_BYTE     = 8'h0F,
    parameter logic [7:0]  END_BYTE       = 8'hF0,
    parameter int          PAYLOAD_BYTES  = 7,
    parameter int          DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_rx_valid,
    input  logic [7:0]              i_rx_byte,
    output logic [8*DATA_BYTES-1:0] o_data,
    output logic [15:0]             o_header,
    output logic                    o_data_valid,
    output logic                    o_wait,
    output logic                    o_ready,
    output logic                    o_retry,
    output logic                    o_frame_err,
    output logic                    o_busy
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = $clog2(PAYLOAD_BYTES + 1) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_CHK,
        ST_END
    } StateT;

    StateT         state, stateNext;
    logic [CW-1:0] byteCnt, byteCntNext;
    logic [7:0]    runXor, runXorNext;
    logic          mismatch, mismatchNext;
    logic [15:0]   hdrShadow, hdrShadowNext;
    logic [DW-1:0] dataShadow, dataShadowNext;
    logic [31:0]   idleCnt, idleCntNext;

    logic [DW-1:0] dataNext;
    logic [15:0]   headerNext;
    logic          dataValidNext, frameErrNext;
    logic          waitNext, readyNext, retryNext;
    logic          timeoutHit;
    logic [DW+7:0] dataShifted;

    // Register every piece of state and every output; reset clears everything, even mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            byteCnt      <= '0;
            runXor       <= '0;
            mismatch     <= 1'b0;
            hdrShadow    <= '0;
            dataShadow   <= '0;
            idleCnt      <= '0;
            o_data       <= '0;
            o_header     <= '0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            o_wait       <= 1'b0;
            o_ready      <= 1'b0;
            o_retry      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= stateNext;
            byteCnt      <= byteCntNext;
            runXor       <= runXorNext;
            mismatch     <= mismatchNext;
            hdrShadow    <= hdrShadowNext;
            dataShadow   <= dataShadowNext;
            idleCnt      <= idleCntNext;
            o_data       <= dataNext;
            o_header     <= headerNext;
            o_data_valid <= dataValidNext;
            o_frame_err  <= frameErrNext;
            o_wait       <= waitNext;
            o_ready      <= readyNext;
            o_retry      <= retryNext;
            o_busy       <= (stateNext != ST_IDLE);
        end
    end

    // Frame parser: next state, running check, shadow registers and the held outputs.
    always_comb begin
        stateNext      = state;
        byteCntNext    = byteCnt;
        runXorNext     = runXor;
        mismatchNext   = mismatch;
        hdrShadowNext  = hdrShadow;
        dataShadowNext = dataShadow;
        idleCntNext    = idleCnt;
        dataNext       = o_data;
        headerNext     = o_header;
        waitNext       = o_wait;
        readyNext      = o_ready;
        retryNext      = o_retry;
        dataValidNext  = 1'b0;
        frameErrNext   = 1'b0;
        dataShifted    = {dataShadow, i_rx_byte};

        // A byte arriving on the would-be timeout edge wins, so the abort needs !i_rx_valid.
        timeoutHit = (TIMEOUT_CYCLES != 0) && (state != ST_IDLE) && !i_rx_valid &&
                     (idleCnt == TIMEOUT_CYCLES - 1);

        if (state == ST_IDLE || i_rx_valid) begin
            idleCntNext = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            idleCntNext = idleCnt + 32'd1;
        end

        if (timeoutHit) begin
            stateNext    = ST_IDLE;
            frameErrNext = 1'b1;
            idleCntNext  = '0;
        end else if (i_rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (i_rx_byte == START_BYTE) begin
                        runXorNext   = '0;
                        byteCntNext  = '0;
                        mismatchNext = 1'b0;
                        stateNext    = ST_HDR;
                    end
                end
                ST_HDR: begin
                    hdrShadowNext = {hdrShadow[7:0], i_rx_byte};
                    runXorNext    = runXor ^ i_rx_byte;
                    if (byteCnt == CW'(1)) begin
                        byteCntNext = '0;
                        stateNext   = ST_PAY;
                    end else begin
                        byteCntNext = byteCnt + 1'b1;
                    end
                end
                ST_PAY: begin
                    runXorNext = runXor ^ i_rx_byte;
                    if (byteCnt < CW'(DATA_BYTES)) begin
                        dataShadowNext = dataShifted[DW-1:0];
                    end
                    if (byteCnt == CW'(PAYLOAD_BYTES - 1)) begin
                        byteCntNext = '0;
                        stateNext   = ST_CHK;
                    end else begin
                        byteCntNext = byteCnt + 1'b1;
                    end
                end
                ST_CHK: begin
                    mismatchNext = (i_rx_byte != runXor);
                    stateNext    = ST_END;
                end
                ST_END: begin
                    stateNext = ST_IDLE;
                    if (i_rx_byte == END_BYTE && !mismatch) begin
                        dataNext      = dataShadow;
                        headerNext    = hdrShadow;
                        waitNext      = (hdrShadow == 16'hFFF1);
                        readyNext     = (hdrShadow == 16'hFFF2);
                        retryNext     = (hdrShadow == 16'hFFF3);
                        dataValidNext = 1'b1;
                    end else begin
                        frameErrNext = 1'b1;
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

endmodule
